// File: rtl/div_seq_pkg.sv
// Shared definitions for the EX-stage divider: state encoding, handshake levels
// and the ALU op codes that select DIV/DIVU.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_seq_step.sv
// One restoring shift-subtract iteration. The working register's top bit is
// shifted out every step, so only the low 2*DATA_W bits are needed as input.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] dend_in,
  input  logic [DATA_W-1:0]   divisor,
  output logic [2*DATA_W:0]   dend_out
);

  logic [DATA_W:0] diff;

  always_comb begin
    diff = {1'b0, dend_in[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
    // A borrow means the partial remainder is smaller than the divisor: restore.
    if (diff[DATA_W]) begin
      dend_out = {dend_in, 1'b0};
    end else begin
      dend_out = {diff[DATA_W-1:0], dend_in[DATA_W-1:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer for EX: magnitude restoring division over
// DATA_W iterations with sign fix-up, stalling EX until the result is ready.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  div_state_e          state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [2*DATA_W:0]   dend, dend_nxt, dend_step;
  logic [DATA_W-1:0]   divisor, divisor_nxt;
  logic                neg_quot, neg_quot_nxt;
  logic                neg_rem, neg_rem_nxt;
  logic [2*DATA_W-1:0] result, result_nxt;
  logic [DATA_W-1:0]   quot_mag, rem_mag;

  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v,
                                                input logic is_signed);
    logic signed [DATA_W-1:0] neg_v;
    neg_v = -v;
    return (is_signed && v[DATA_W-1]) ? $unsigned(neg_v) : $unsigned(v);
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

  div_step #(.DATA_W(DATA_W)) u_step (
    .dend_in  (dend[2*DATA_W-1:0]),
    .divisor  (divisor),
    .dend_out (dend_step)
  );

  assign quot_mag = dend[DATA_W-1:0];
  assign rem_mag  = dend[2*DATA_W:DATA_W+1];

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    dend_nxt     = dend;
    divisor_nxt  = divisor;
    neg_quot_nxt = neg_quot;
    neg_rem_nxt  = neg_rem;
    result_nxt   = result;
    case (state)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_nxt = DivByZero;
          end else begin
            state_nxt    = DivOn;
            divisor_nxt  = abs_val(opdata2_i, signed_div_i);
            neg_quot_nxt = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_rem_nxt  = signed_div_i & opdata1_i[DATA_W-1];
            dend_nxt     = {{DATA_W{1'b0}}, abs_val(opdata1_i, signed_div_i), 1'b0};
            cnt_nxt      = '0;
          end
        end
      end
      DivByZero: begin
        state_nxt  = annul_i ? DivFree : DivEnd;
        result_nxt = '0;
      end
      DivOn: begin
        if (annul_i) begin
          state_nxt  = DivFree;
          result_nxt = '0;
          cnt_nxt    = '0;
        end else if (cnt != CNT_W'(DATA_W)) begin
          dend_nxt = dend_step;
          cnt_nxt  = cnt + CNT_W'(1);
        end else begin
          // Magnitudes are done; restore signs (remainder follows the dividend).
          result_nxt = {cond_neg(rem_mag, neg_rem), cond_neg(quot_mag, neg_quot)};
          state_nxt  = DivEnd;
          cnt_nxt    = '0;
        end
      end
      DivEnd: begin
        if (annul_i || start_i == DivStop) begin
          state_nxt  = DivFree;
          result_nxt = '0;
        end
      end
      default: begin
        state_nxt  = DivFree;
        result_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DivFree;
      cnt      <= '0;
      dend     <= '0;
      divisor  <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result   <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dend     <= dend_nxt;
      divisor  <= divisor_nxt;
      neg_quot <= neg_quot_nxt;
      neg_rem  <= neg_rem_nxt;
      result   <= result_nxt;
    end
  end

  assign result_o   = result;
  assign ready_o    = (state == DivEnd) ? DivResultReady : DivResultNotReady;
  assign stallreq_o = start_i & ~annul_i & (state != DivEnd);

endmodule

// File: tb/tb_div_seq.sv
// Randomized self-checking bench for div_seq against an arithmetic reference model.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready, stallreq;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  div_seq #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference: {remainder, quotient} from plain integer division.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string tag);
    logic [63:0] exp_r;
    int          exp_lat, lat;
    bit          stall_ok, hold_ok;
    exp_r   = ref_div(sgn, a, b);
    exp_lat = (b == 0) ? 1 : 33;
    signed_div = sgn; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
    #1;
    stall_ok = (stallreq === 1'b1);
    tick();
    // Operands are latched at the start edge; scramble them afterwards.
    op1 = $urandom; op2 = $urandom; signed_div = ~sgn;
    lat = 0;
    while (ready !== 1'b1 && lat < 40) begin
      if (stallreq !== 1'b1) stall_ok = 1'b0;
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, result, exp_r);
    check({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
    check({tag, "_stall_rdy"}, 64'(stallreq), 64'd0);
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (ready !== 1'b1 || result !== exp_r) hold_ok = 1'b0;
    end
    if (hold > 0) check({tag, "_hold"}, 64'(hold_ok), 64'd1);
    start = 1'b0;
    tick();
    check({tag, "_rel_rdy"}, 64'(ready), 64'd0);
    check({tag, "_rel_res"}, result, 64'd0);
  endtask

  initial begin
    bit          sgn, quiet;
    logic [31:0] a, b;

    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    op1 = 32'd0; op2 = 32'd0;
    tick(); tick();
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_stall", 64'(stallreq), 64'd0);
    rst = 1'b0;
    tick();

    run_div(1'b0, 32'd100, 32'd7, 0, "u100_7");
    check("u100_7_const", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
    run_div(1'b1, 32'hFFFFFFF9, 32'h2, 0, "s_m7_2");
    run_div(1'b1, 32'h7, 32'hFFFFFFFE, 0, "s_7_m2");
    run_div(1'b0, 32'h12345678, 32'h0, 0, "byzero");
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, "ovf");

    // Annul mid-iteration: no result may ever appear.
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    tick();
    repeat (10) tick();
    annul = 1'b1; start = 1'b0;
    tick();
    annul = 1'b0;
    check("annul_rdy", 64'(ready), 64'd0);
    check("annul_res", result, 64'd0);
    quiet = 1'b1;
    repeat (40) begin
      tick();
      if (ready !== 1'b0) quiet = 1'b0;
    end
    check("annul_quiet", 64'(quiet), 64'd1);
    run_div(1'b0, 32'hFFFFFFFF, 32'h10, 0, "post_annul");

    // Reset in the middle of an operation.
    signed_div = 1'b1; op1 = 32'h1234; op2 = 32'h5;
    start = 1'b1;
    tick();
    repeat (20) tick();
    rst = 1'b1; start = 1'b0;
    tick();
    rst = 1'b0;
    check("midrst_rdy", 64'(ready), 64'd0);
    check("midrst_res", result, 64'd0);
    check("midrst_stall", 64'(stallreq), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, 0, "post_rst");

    run_div(1'b0, 32'd100, 32'd7, 5, "hold5");

    for (int n = 0; n < 20; n++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom >> $urandom_range(0, 31);
      if (n == 7) b = 32'd0;
      if (n == 11) a = 32'd0;
      run_div(sgn, a, b, $urandom_range(0, 2), $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
